dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_pkg.sv | 19 +
 rtl/dmem_ctrl_if.sv | 28 ++
 rtl/dmem_ctrl_wbuf_fifo.sv | 69 ++++++
 rtl/dmem_ctrl.sv | 155 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared CPU data-memory types: controller FSM states and write-buffer entries.
package lib_cpu;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2
  } DMC_STATE;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } wbuf_entry_t;

  function automatic logic [31:0] byte_addr(input logic [29:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// CPU-side and memory-side signals of the data-memory controller.
interface dmem_ctrl_if;

  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_rdata;
  logic        stall;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_ack, mem_rdata,
    output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_ack, mem_rdata,
    input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_ctrl_wbuf_fifo.sv
// Store write buffer: circular FIFO with a youngest-match address lookup
// so loads can be forwarded from stores that have not reached memory yet.
module wbuf_fifo
  import lib_cpu::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  wbuf_entry_t       push_entry,
  input  logic              pop,
  output wbuf_entry_t       head,
  input  logic [29:0]       lookup_addr,
  output logic              hit,
  output logic [31:0]       hit_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  wbuf_entry_t      storage [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] idx;

  assign head  = storage[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Entry storage has no reset; the occupancy count decides which slots are live
  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr] <= push_entry;
  end

  // Pointer and occupancy bookkeeping; power-of-two depth makes the pointers wrap on their own
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Scan live entries oldest to youngest so the youngest match overrides older ones
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (storage[idx].addr == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = storage[idx].data;
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: buffers stores, forwards buffered data to loads,
// and lets load misses bypass pending stores on the way to memory.
module dmem_ctrl
  import lib_cpu::*;
#(
  parameter int DEPTH       = 4,
  parameter int MEM_LAT_MAX = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  dmem_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  DMC_STATE         state;
  DMC_STATE         state_nxt;
  logic [29:0]      word_addr;
  logic             store_req;
  logic             load_req;
  logic             stall_raw;
  logic             push;
  logic             pop;
  logic             hit;
  logic             full;
  logic             empty;
  logic [31:0]      hit_data;
  logic [31:0]      rdata;
  logic [CNT_W-1:0] count;
  wbuf_entry_t      head;
  wbuf_entry_t      push_entry;
  wbuf_entry_t      launch;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_wdata_q;

  // A simultaneous store and load is a store; the load request is dropped
  assign word_addr  = bus.cpu_addr[31:2];
  assign store_req  = bus.cpu_we;
  assign load_req   = bus.cpu_re & ~bus.cpu_we;
  assign push_entry = '{addr: word_addr, data: bus.cpu_wdata};
  assign push       = store_req & ~stall_raw;
  assign pop        = (state == DRAIN) & bus.mem_ack;

  // With an empty buffer the store being accepted this cycle is drained straight away
  assign launch = empty ? push_entry : head;

  wbuf_fifo #(.DEPTH(DEPTH)) u_wbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .head        (head),
    .lookup_addr (word_addr),
    .hit         (hit),
    .hit_data    (hit_data),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, CPU stall and load data; read misses win over drains in IDLE
  always_comb begin
    state_nxt = state;
    stall_raw = 1'b0;
    rdata     = '0;
    case (state)
      IDLE: begin
        if (load_req && !hit) begin
          state_nxt = READ;
          stall_raw = 1'b1;
        end else if (!empty || store_req) begin
          state_nxt = DRAIN;
        end
        if (store_req && full) stall_raw = 1'b1;
        if (load_req && hit)   rdata     = hit_data;
      end
      DRAIN: begin
        if (bus.mem_ack) state_nxt = IDLE;
        if (store_req && full && !bus.mem_ack) stall_raw = 1'b1;
        if (load_req) begin
          if (hit) rdata     = hit_data;
          else     stall_raw = 1'b1;
        end
      end
      READ: begin
        stall_raw = ~bus.mem_ack;
        if (bus.mem_ack) begin
          state_nxt = IDLE;
          rdata     = bus.mem_rdata;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the transaction fields when leaving IDLE and hold them until the ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (state == IDLE) begin
      if (state_nxt == READ) begin
        mem_we_q    <= 1'b0;
        mem_addr_q  <= byte_addr(word_addr);
        mem_wdata_q <= '0;
      end else if (state_nxt == DRAIN) begin
        mem_we_q    <= 1'b1;
        mem_addr_q  <= byte_addr(launch.addr);
        mem_wdata_q <= launch.data;
      end else begin
        mem_we_q    <= 1'b0;
        mem_addr_q  <= '0;
        mem_wdata_q <= '0;
      end
    end else if (bus.mem_ack) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end
  end

  assign bus.mem_req   = (state != IDLE);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_rdata = rdata;
  assign bus.stall     = stall_raw & rst_n;

`ifndef SYNTHESIS
  logic [31:0] wait_cnt;

  // Count cycles a request has been outstanding without an ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         wait_cnt <= '0;
    else if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1'b1;
    else                                wait_cnt <= '0;
  end

  // Memory latency bound, only enforced when a bound is configured
  always_ff @(posedge clk) begin
    if (rst_n && (MEM_LAT_MAX > 0) && bus.mem_req)
      assert (wait_cnt < $unsigned(MEM_LAT_MAX));
  end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with store/load scoreboards.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [63:0] exp_wr[$];
  logic [31:0] exp_rd[$];

  dmem_ctrl_if bus();

  dmem_ctrl #(.DEPTH(4), .MEM_LAT_MAX(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wdata);
    bus.cpu_we    = we;
    bus.cpu_re    = re;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic storeWord(input string tag, input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, addr, data);
    exp_wr.push_back({addr & 32'hFFFF_FFFC, data});
    @(negedge clk);
    checkOutput(tag, bus.stall, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  task automatic checkDrainHead(input string tag);
    logic [63:0] e;
    if (exp_wr.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s: drain observed addr=0x%08h required no write", tag, bus.mem_addr);
    end else begin
      e = exp_wr.pop_front();
      checkOutput({tag, "_req"},  bus.mem_req,   1'b1);
      checkOutput({tag, "_we"},   bus.mem_we,    1'b1);
      checkOutput({tag, "_addr"}, bus.mem_addr,  e[63:32]);
      checkOutput({tag, "_data"}, bus.mem_wdata, e[31:0]);
    end
  endtask

  task automatic drainOne(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus.mem_req === 1'b1 && bus.mem_we === 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s: drain timeout, observed mem_req=%0b required=1", tag, bus.mem_req);
      nextCycle();
    end else begin
      checkDrainHead(tag);
      bus.mem_ack = 1'b1;
      nextCycle();
      bus.mem_ack = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_mem_req",   bus.mem_req,   1'b0);
    checkOutput("rst_mem_we",    bus.mem_we,    1'b0);
    checkOutput("rst_mem_addr",  bus.mem_addr,  32'h0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 32'h0);
    checkOutput("rst_stall",     bus.stall,     1'b0);
    checkOutput("rst_count",     32'(dut.count), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    nextCycle();

    $display("[TB] single store drains on the next cycle");
    applyStimulus(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    exp_wr.push_back({32'h10, 32'hDEADBEEF});
    @(negedge clk);
    checkOutput("a_store_stall", bus.stall, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkDrainHead("a_drain");
    bus.mem_ack = 1'b1;
    nextCycle();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("a_count",    32'(dut.count), 32'd0);
    checkOutput("a_req_idle", bus.mem_req, 1'b0);
    nextCycle();

    $display("[TB] youngest-match forwarding");
    storeWord("b_st1", 32'h20, 32'd1);
    storeWord("b_st2", 32'h20, 32'd2);
    applyStimulus(1'b0, 1'b1, 32'h22, '0);
    exp_rd.push_back(32'd2);
    @(negedge clk);
    checkOutput("b_fwd_stall", bus.stall, 1'b0);
    checkOutput("b_fwd_data",  bus.cpu_rdata, exp_rd.pop_front());
    checkOutput("b_count",     32'(dut.count), 32'd2);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
    drainOne("b_drain1");
    drainOne("b_drain2");

    $display("[TB] load miss with three-cycle memory latency");
    applyStimulus(1'b0, 1'b1, 32'h40, '0);
    exp_rd.push_back(32'h1234);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("c_miss_stall", bus.stall, 1'b1);
      if (k == 1) begin
        checkOutput("c_read_addr", bus.mem_addr, 32'h40);
        checkOutput("c_read_we",   bus.mem_we,   1'b0);
      end
      nextCycle();
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234;
    @(negedge clk);
    checkOutput("c_ack_stall", bus.stall, 1'b0);
    checkOutput("c_ack_data",  bus.cpu_rdata, exp_rd.pop_front());
    nextCycle();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("c_idle_rdata", bus.cpu_rdata, 32'h0);
    checkOutput("c_idle_req",   bus.mem_req,   1'b0);
    nextCycle();

    $display("[TB] full buffer stalls, drain ack admits the waiting store");
    for (int i = 0; i < 4; i++)
      storeWord("d_fill_stall", 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
    applyStimulus(1'b1, 1'b0, 32'h110, 32'hA4);
    @(negedge clk);
    checkOutput("d_full_stall", bus.stall, 1'b1);
    nextCycle();
    @(negedge clk);
    checkOutput("d_full_stall2", bus.stall, 1'b1);
    checkOutput("d_full_count",  32'(dut.count), 32'd4);
    bus.mem_ack = 1'b1;
    #1;
    checkOutput("d_ack_stall", bus.stall, 1'b0);
    checkDrainHead("d_head");
    exp_wr.push_back({32'h110, 32'hA4});
    nextCycle();
    bus.mem_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("d_after_count", 32'(dut.count), 32'd4);
    nextCycle();
    for (int i = 0; i < 4; i++) drainOne("d_drain");

    $display("[TB] read miss bypasses buffered stores");
    storeWord("e_st1", 32'h200, 32'h11);
    storeWord("e_st2", 32'h204, 32'h22);
    storeWord("e_st3", 32'h208, 32'h33);
    drainOne("e_drain_first");
    applyStimulus(1'b0, 1'b1, 32'h80, '0);
    exp_rd.push_back(32'h5555);
    @(negedge clk);
    checkOutput("e_miss_stall", bus.stall, 1'b1);
    checkOutput("e_miss_count", 32'(dut.count), 32'd2);
    nextCycle();
    @(negedge clk);
    checkOutput("e_read_req",   bus.mem_req,  1'b1);
    checkOutput("e_read_we",    bus.mem_we,   1'b0);
    checkOutput("e_read_addr",  bus.mem_addr, 32'h80);
    checkOutput("e_read_count", 32'(dut.count), 32'd2);
    nextCycle();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555;
    @(negedge clk);
    checkOutput("e_ack_stall", bus.stall, 1'b0);
    checkOutput("e_ack_data",  bus.cpu_rdata, exp_rd.pop_front());
    nextCycle();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    drainOne("e_drain2");
    drainOne("e_drain3");

    $display("[TB] store and load together act as a store");
    storeWord("f_we_re_stall", 32'h300, 32'h77);
    applyStimulus(1'b1, 1'b1, 32'h304, 32'h78);
    exp_wr.push_back({32'h304, 32'h78});
    @(negedge clk);
    checkOutput("f_both_stall", bus.stall, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
    drainOne("f_drain1");
    drainOne("f_drain2");

    $display("[TB] reset during a read abandons everything");
    storeWord("g_st1", 32'h400, 32'h44);
    storeWord("g_st2", 32'h404, 32'h55);
    drainOne("g_drain");
    applyStimulus(1'b0, 1'b1, 32'hC0, '0);
    nextCycle();
    @(negedge clk);
    checkOutput("g_read_req",   bus.mem_req, 1'b1);
    checkOutput("g_read_count", 32'(dut.count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("g_rst_req",   bus.mem_req,  1'b0);
    checkOutput("g_rst_stall", bus.stall,    1'b0);
    checkOutput("g_rst_count", 32'(dut.count), 32'd0);
    checkOutput("g_rst_addr",  bus.mem_addr, 32'h0);
    exp_wr.delete();
    applyStimulus(1'b0, 1'b0, '0, '0);
    @(negedge clk) rst_n = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("g_post_req",   bus.mem_req, 1'b0);
    checkOutput("g_post_count", 32'(dut.count), 32'd0);

    checkOutput("sb_wr_empty", 32'(exp_wr.size()), 32'd0);
    checkOutput("sb_rd_empty", 32'(exp_rd.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
